// File: rtl/rv_mem_pkg.sv
// Constants and the loader state encoding shared by the instruction memory and
// its loader.
package rv_mem_pkg;

  localparam int MEM_BYTES      = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    LD_IDLE      = 3'd0,
    LD_CHECK     = 3'd1,
    LD_WAIT_WORD = 3'd2,
    LD_WRITE     = 3'd3,
    LD_FINISH    = 3'd4
  } loader_state_e;

endpackage

// File: rtl/inst_mem_loader.sv
// Streams 32-bit instruction words into the byte-wide instruction memory write
// port, little-endian, and holds the core in reset until an image has loaded.
module inst_mem_loader
  import rv_mem_pkg::*;
#(
  parameter int MEM_BYTES = rv_mem_pkg::MEM_BYTES,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  localparam logic [2:0] IDLE      = LD_IDLE;
  localparam logic [2:0] CHECK     = LD_CHECK;
  localparam logic [2:0] WAIT_WORD = LD_WAIT_WORD;
  localparam logic [2:0] WRITE     = LD_WRITE;
  localparam logic [2:0] FINISH    = LD_FINISH;

  // Wide enough that base + 4*count can never wrap before the bound compare.
  localparam int BW = ADDR_W + CNT_W + 2;

  logic [2:0]        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [31:0]       word_q;
  logic [1:0]        b_q;

  logic [BW-1:0] end_addr;
  logic          range_ok;
  logic [1:0]    b_next;

  assign end_addr = BW'(addr_q) + (BW'(remaining_q) << 2);
  assign range_ok = (addr_q[1:0] == 2'b00) && (end_addr <= BW'(MEM_BYTES));
  assign b_next   = b_q + 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      b_q         <= '0;
      in_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cpu_hold    <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= CHECK;
            addr_q      <= base_addr;
            remaining_q <= word_count;
            error       <= 1'b0;
            busy        <= 1'b1;
          end
        end
        CHECK: begin
          if (!range_ok) begin
            // Rejected session: report it but leave cpu_hold alone.
            error   <= 1'b1;
            done    <= 1'b1;
            state_q <= FINISH;
          end else if (remaining_q == '0) begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            state_q  <= FINISH;
          end else begin
            in_ready <= 1'b1;
            state_q  <= WAIT_WORD;
          end
        end
        WAIT_WORD: begin
          if (in_valid && in_ready) begin
            word_q    <= in_data;
            b_q       <= 2'd0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= addr_q;
            mem_wdata <= in_data[7:0];
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          if (b_q == 2'd3) begin
            mem_we      <= 1'b0;
            addr_q      <= addr_q + ADDR_W'(BYTES_PER_WORD);
            remaining_q <= remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              state_q  <= FINISH;
            end else begin
              in_ready <= 1'b1;
              state_q  <= WAIT_WORD;
            end
          end else begin
            b_q       <= b_next;
            mem_addr  <= addr_q + ADDR_W'(b_next);
            mem_wdata <= word_q[{b_next, 3'b000} +: 8];
          end
        end
        FINISH: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          mem_we   <= 1'b0;
          busy     <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader with a byte-array stand-in for the
// instruction memory on the write port.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [32];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  bit          oob = 1'b0;
  logic [15:0] wlog [$];

  inst_mem_loader #(.MEM_BYTES(32), .ADDR_W(32), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_addr < 32) mem[mem_addr[4:0]] <= mem_wdata;
      else oob <= 1'b1;
      wr_cnt <= wr_cnt + 1;
      wlog.push_back({mem_addr[7:0], mem_wdata});
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat_word(input int k);
    logic [7:0] b0;
    b0 = 8'hA0 + 8'(4 * k);
    return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
  endfunction

  // Runs one session with in_valid held high; done_at counts edges after the
  // edge that sampled start.
  task automatic run_session(input logic [31:0] base, input logic [7:0] cnt,
                             input logic [31:0] w0, input bit pattern,
                             output int writes, output int readies, output int done_at,
                             output logic hold_at_done, output logic err_at_check);
    int  wr0;
    int  widx;
    bit  hs;
    bit  finished;
    wr0        = wr_cnt;
    widx       = 0;
    finished   = 1'b0;
    readies    = 0;
    done_at    = -1;
    hold_at_done = 1'bx;
    base_addr  = base;
    word_count = cnt;
    in_data    = pattern ? pat_word(0) : w0;
    in_valid   = 1'b1;
    start      = 1'b1;
    step();
    start        = 1'b0;
    err_at_check = error;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (in_ready) readies++;
      hs = in_ready && in_valid;
      step();
      if (hs) begin
        widx++;
        in_data = pattern ? pat_word(widx) : 32'h0;
      end
      if (done) begin
        done_at      = cyc + 1;
        hold_at_done = cpu_hold;
      end
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) check("session_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    writes   = wr_cnt - wr0;
    $display("txn base=%0d count=%0d writes=%0d readies=%0d done_at=%0d error=%0b cpu_hold=%0b",
             base, cnt, writes, readies, done_at, error, cpu_hold);
  endtask

  initial begin
    int   writes, readies, done_at, idx, bad, wr0, dc;
    logic hold_d, err_c;

    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_data = '0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cpu_hold", cpu_hold, 1);
    step(); step();
    reset = 1'b0;
    step();

    // Out-of-range image: 28 + 8 > 32
    run_session(32'd28, 8'd2, 32'h0, 1'b0, writes, readies, done_at, hold_d, err_c);
    check("oor_writes", writes, 0);
    check("oor_done_at", done_at, 1);
    check("oor_error", error, 1);
    check("oor_hold", cpu_hold, 1);

    // Misaligned base; error must clear on the accepted start first
    run_session(32'd2, 8'd1, 32'h0, 1'b0, writes, readies, done_at, hold_d, err_c);
    check("mis_err_cleared", err_c, 0);
    check("mis_writes", writes, 0);
    check("mis_error", error, 1);
    check("mis_hold", cpu_hold, 1);

    // Single word at base 4
    idx = wlog.size();
    run_session(32'd4, 8'd1, 32'h413903b3, 1'b0, writes, readies, done_at, hold_d, err_c);
    check("one_writes", writes, 4);
    check("one_done_at", done_at, 6);
    check("one_hold_at_done", hold_d, 0);
    check("one_error", error, 0);
    check("one_w0", wlog[idx], 16'h04b3);
    check("one_w1", wlog[idx+1], 16'h0503);
    check("one_w2", wlog[idx+2], 16'h0639);
    check("one_w3", wlog[idx+3], 16'h0741);
    check("one_fetch_pc4", {mem[7], mem[6], mem[5], mem[4]}, 32'h413903b3);

    // Full 32-byte image, streamed back to back
    run_session(32'd0, 8'd8, 32'h0, 1'b1, writes, readies, done_at, hold_d, err_c);
    check("full_writes", writes, 32);
    check("full_readies", readies, 8);
    check("full_done_at", done_at, 41);
    check("full_error", error, 0);
    check("full_oob", oob, 0);
    bad = 0;
    for (int a = 0; a < 32; a++) if (mem[a] !== 8'hA0 + 8'(a)) bad++;
    check("full_image_bad_bytes", bad, 0);

    // Empty session
    run_session(32'd0, 8'd0, 32'h0, 1'b0, writes, readies, done_at, hold_d, err_c);
    check("zero_writes", writes, 0);
    check("zero_done_at", done_at, 1);
    check("zero_error", error, 0);
    check("zero_hold", cpu_hold, 0);

    // Stall in WAIT_WORD with a stray start pulse
    wr0 = wr_cnt;
    base_addr = 32'd8; word_count = 8'd1; in_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_we || !busy || !in_ready) bad++;
      if (i == 4) begin
        start = 1'b1; base_addr = 32'd0; word_count = 8'd0;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    check("stall_bad_cycles", bad, 0);
    check("stall_writes", wr_cnt - wr0, 0);
    in_valid = 1'b1; in_data = 32'hCAFEF00D;
    step();
    in_valid = 1'b0; in_data = 32'h0;
    check("stall_we", mem_we, 1);
    check("stall_addr", mem_addr, 8);
    check("stall_wdata", mem_wdata, 8'h0D);
    step(); step(); step(); step();
    check("stall_done", done, 1);
    step();
    check("stall_word", {mem[11], mem[10], mem[9], mem[8]}, 32'hCAFEF00D);
    $display("txn stall base=8 count=1 word=%h", {mem[11], mem[10], mem[9], mem[8]});

    // Reset after the second byte of a word
    base_addr = 32'd16; word_count = 8'd1; in_valid = 1'b1; in_data = 32'h55667788; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    in_valid = 1'b0;
    step();
    step();
    dc = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("abort_we", mem_we, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_hold", cpu_hold, 1);
    step(); step();
    reset = 1'b0;
    step(); step();
    check("abort_no_done", done_cnt, dc);
    check("abort_bytes", {mem[19], mem[18], mem[17], mem[16]}, 32'hB3B27788);
    $display("txn abort base=16 bytes=%h", {mem[19], mem[18], mem[17], mem[16]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
